// File: rtl/pool_apb_master.sv
// APB initiator for the pool accelerator: command FIFO feeding a SETUP/ACCESS/RESP sequencer.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module pool_apb_master #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              BUSY,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PSLVERR
);

    localparam int unsigned PtrW = $clog2(CMD_DEPTH);
    localparam int unsigned EntW = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e state_q, state_d;

    logic [EntW-1:0]   fifo_mem [CMD_DEPTH];
    logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full;
    logic              push, pop;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              tmo_hit;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

    assign CMD_READY = RESETN && !fifo_full;
    assign push      = CMD_VALID && CMD_READY;
    assign pop       = (state_q == StIdle) && !fifo_empty;

    assign {head_write, head_addr, head_wdata} = fifo_mem[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PtrW-1:0]] <= {CMD_WRITE, CMD_ADDR, CMD_WDATA};
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] tmo_cnt_q;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StSetup) begin
            tmo_cnt_q <= '0;
        end else if (state_q == StAccess) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Fires on the TIMEOUT-th ACCESS cycle that still sees no PREADY.
    assign tmo_hit = (state_q == StAccess) && !PREADY &&
                     (tmo_cnt_q == CntW'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        RSP_VALID = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) state_d = StSetup;
            end
            StSetup: begin
                PSEL    = 1'b1;
                state_d = StAccess;
            end
            StAccess: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || tmo_hit) state_d = StResp;
            end
            StResp: begin
                RSP_VALID = 1'b1;
                if (RSP_READY) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                paddr_q  <= head_addr;
                pwrite_q <= head_write;
                pwdata_q <= head_write ? head_wdata : '0;
            end
            if (state_q == StAccess) begin
                if (PREADY) begin
                    rdata_q <= pwrite_q ? '0 : PRDATA;
                    err_q   <= PSLVERR;
                end else if (tmo_hit) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;
    assign BUSY      = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_pool_apb_master.sv
// Directed bench for pool_apb_master; define APB_TIMEOUT_EN to also exercise the watchdog.
module tb_pool_apb_master;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned Tmo = 8;
`else
    localparam int unsigned Tmo = 255;
`endif

    logic        CLK = 1'b0;
    logic        RESETN;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [31:0] CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic        BUSY;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;
    bit auto_rd = 1'b0;

    pool_apb_master #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .CMD_DEPTH(4),
        .TIMEOUT  (Tmo)
    ) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .CMD_VALID(CMD_VALID),
        .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR (CMD_ADDR),
        .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_RDATA(RSP_RDATA),
        .RSP_ERR  (RSP_ERR),
        .BUSY     (BUSY),
        .PADDR    (PADDR),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PREADY   (PREADY),
        .PRDATA   (PRDATA),
        .PSLVERR  (PSLVERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Advance one cycle and observe 1ns after the edge; optional slave returns an address tag.
    task automatic tick();
        @(posedge CLK);
        #1;
        if (auto_rd) PRDATA = {16'hA5A5, PADDR[15:0]};
    endtask

    task automatic push_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        CMD_VALID = 1'b1;
        CMD_WRITE = w;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int g = 0;
        while (!RSP_VALID && g < 100) begin
            tick();
            g++;
        end
        ok = RSP_VALID;
    endtask

    task automatic test_reset();
        RESETN    = 1'b0;
        CMD_VALID = 1'b0;
        CMD_WRITE = 1'b0;
        CMD_ADDR  = '0;
        CMD_WDATA = '0;
        RSP_READY = 1'b1;
        PREADY    = 1'b1;
        PRDATA    = '0;
        PSLVERR   = 1'b0;
        repeat (3) tick();
        checks++;
        if ({PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, BUSY} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {PSEL, PENABLE, PWRITE, RSP_VALID, RSP_ERR, BUSY});
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || RSP_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", PADDR, PWDATA,
                     RSP_RDATA);
        end
        checks++;
        if (CMD_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b want 0", CMD_READY);
        end
        RESETN = 1'b1;
        tick();
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_high: got %b want 1", CMD_READY);
        end
    endtask

    task automatic test_write_latency();
        PREADY    = 1'b1;
        PRDATA    = 32'hDEAD_BEEF;
        RSP_READY = 1'b1;
        push_cmd(1'b1, 32'h4, 32'd12);
        // now in cycle n+1
        checks++;
        if (PSEL !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL wr_n1: psel=%b busy=%b want 0 1", PSEL, BUSY);
        end
        tick();
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b0 || PADDR !== 32'h4 || PWRITE !== 1'b1 ||
            PWDATA !== 32'd12) begin
            errors++;
            $display("FAIL wr_setup: psel=%b pen=%b paddr=%h pw=%b pwdata=%h want 1 0 4 1 c",
                     PSEL, PENABLE, PADDR, PWRITE, PWDATA);
        end
        tick();
        checks++;
        if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
            errors++;
            $display("FAIL wr_access: psel=%b pen=%b want 1 1", PSEL, PENABLE);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'h0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL wr_resp: valid=%b err=%b rdata=%h psel=%b want 1 0 0 0", RSP_VALID,
                     RSP_ERR, RSP_RDATA, PSEL);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b0 || PADDR !== 32'h4) begin
            errors++;
            $display("FAIL wr_idle: valid=%b busy=%b paddr=%h want 0 0 4", RSP_VALID, BUSY, PADDR);
        end
    endtask

    task automatic test_read_wait();
        int en = 0;
        bit addr_bad = 1'b0;
        PREADY = 1'b0;
        PRDATA = 32'h1234;
        push_cmd(1'b0, 32'h8, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (PSEL !== 1'b1 || PADDR !== 32'h8 || PWRITE !== 1'b0 || PWDATA !== 32'h0) begin
            errors++;
            $display("FAIL rd_setup: psel=%b paddr=%h pw=%b pwdata=%h want 1 8 0 0", PSEL, PADDR,
                     PWRITE, PWDATA);
        end
        tick();
        while (PENABLE === 1'b1 && en < 20) begin
            en++;
            if (PADDR !== 32'h8 || PSEL !== 1'b1) addr_bad = 1'b1;
            PREADY = (en >= 4);
            tick();
        end
        PREADY = 1'b0;
        checks++;
        if (en != 4) begin
            errors++;
            $display("FAIL rd_penable_cycles: got %0d want 4", en);
        end
        checks++;
        if (addr_bad) begin
            errors++;
            $display("FAIL rd_paddr_stable: got unstable want 8 throughout");
        end
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'h1234 || RSP_ERR !== 1'b0) begin
            errors++;
            $display("FAIL rd_resp: valid=%b rdata=%h err=%b want 1 1234 0", RSP_VALID, RSP_RDATA,
                     RSP_ERR);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int rsp = 0;
        int g = 0;
        auto_rd   = 1'b1;
        PREADY    = 1'b1;
        RSP_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            CMD_VALID = 1'b1;
            CMD_WRITE = 1'b0;
            CMD_ADDR  = 32'h100 + 32'(4 * i);
            CMD_WDATA = 32'h0;
            checks++;
            if (CMD_READY !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, CMD_READY);
            end
            tick();
        end
        checks++;
        if (CMD_READY !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_full: ready=%b busy=%b want 0 1", CMD_READY, BUSY);
        end
        CMD_VALID = 1'b0;
        repeat (2) tick();
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'hA5A5_0100 || CMD_READY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: valid=%b rdata=%h ready=%b want 1 a5a50100 0", RSP_VALID,
                     RSP_RDATA, CMD_READY);
        end
        RSP_READY = 1'b1;
        while (rsp < 5 && g < 100) begin
            if (RSP_VALID === 1'b1) begin
                checks++;
                if (RSP_RDATA !== 32'hA5A5_0100 + 32'(4 * rsp)) begin
                    errors++;
                    $display("FAIL b2b_order_%0d: got %h want %h", rsp, RSP_RDATA,
                             32'hA5A5_0100 + 32'(4 * rsp));
                end
                rsp++;
            end
            tick();
            g++;
        end
        checks++;
        if (rsp != 5 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got %0d rsp busy=%b want 5 0", rsp, BUSY);
        end
    endtask

    task automatic test_slverr();
        bit ok;
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        push_cmd(1'b1, 32'hFC, 32'h55);
        wait_rsp(ok);
        checks++;
        if (!ok || RSP_ERR !== 1'b1 || RSP_RDATA !== 32'h0) begin
            errors++;
            $display("FAIL slverr_resp: valid=%b err=%b rdata=%h want 1 1 0", ok, RSP_ERR,
                     RSP_RDATA);
        end
        PSLVERR = 1'b0;
        tick();
        push_cmd(1'b0, 32'h10, 32'h0);
        wait_rsp(ok);
        checks++;
        if (!ok || RSP_ERR !== 1'b0 || RSP_RDATA !== 32'hA5A5_0010) begin
            errors++;
            $display("FAIL slverr_next: valid=%b err=%b rdata=%h want 1 0 a5a50010", ok, RSP_ERR,
                     RSP_RDATA);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit stray = 1'b0;
        PREADY = 1'b0;
        CMD_WRITE = 1'b1;
        CMD_WDATA = 32'h77;
        CMD_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            CMD_ADDR = 32'h200 + 32'(4 * i);
            tick();
        end
        CMD_VALID = 1'b0;
        checks++;
        if (PENABLE !== 1'b1 || PADDR !== 32'h200) begin
            errors++;
            $display("FAIL rstmid_access: pen=%b paddr=%h want 1 200", PENABLE, PADDR);
        end
        RESETN = 1'b0;
        tick();
        checks++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || BUSY !== 1'b0 || RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop: psel=%b pen=%b busy=%b valid=%b want 0 0 0 0", PSEL,
                     PENABLE, BUSY, RSP_VALID);
        end
        RESETN = 1'b1;
        PREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) stray = 1'b1;
            tick();
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rstmid_flush: got activity after reset want none");
        end
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        int en = 0;
        PREADY    = 1'b0;
        RSP_READY = 1'b1;
        push_cmd(1'b0, 32'h8, 32'h0);
        repeat (2) tick();
        while (PENABLE === 1'b1 && en < 50) begin
            en++;
            tick();
        end
        checks++;
        if (en != 8) begin
            errors++;
            $display("FAIL tmo_cycles: got %0d want 8", en);
        end
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_ERR !== 1'b1 || RSP_RDATA !== 32'h0 || PSEL !== 1'b0) begin
            errors++;
            $display("FAIL tmo_resp: valid=%b err=%b rdata=%h psel=%b want 1 1 0 0", RSP_VALID,
                     RSP_ERR, RSP_RDATA, PSEL);
        end
        PREADY = 1'b1;
        tick();
        checks++;
        if (BUSY !== 1'b0 || RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late_ready: busy=%b valid=%b want 0 0", BUSY, RSP_VALID);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_latency();
        test_read_wait();
        test_back_to_back();
        test_slverr();
        test_reset_mid();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
